ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/npc_pkg.sv | 26 ++
 rtl/ifu.sv | 158 +++++++++++++++
 tb/tb_ifu.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// npc_pkg - definitions shared between the fetch unit and the next-PC logic.
//
// Contents:
//   RESET_PC_DEFAULT - PC loaded at reset unless a parent overrides it
//   ifu_state_e      - fetch FSM states
//   pc_is_aligned    - true when a PC is on a 4-byte boundary

package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // The state ordering is also the natural order of one fetch-execute
  // round trip; IDLE is only visited once, straight out of reset.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_EXEC = 3'd4
  } ifu_state_e;

  function automatic logic pc_is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage : npc_pkg

// File: rtl/ifu.sv
// ifu - instruction fetch unit.
//
// Runs one instruction at a time through a simple loop. It requests the
// word at pc, waits for the memory response, hands the instruction to
// decode, then waits for the commit of that instruction. The commit
// supplies the next pc. Only one fetch is ever outstanding. A misaligned
// pc never reaches memory. Instead it produces a faulting bubble (inst=0,
// inst_fault=1) on the decode channel.
//
// Every output is either a flop or the pc register itself, so there is no
// combinational path from any input to any output.
//
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   pc                             current PC, feeds external next-PC logic
//   next_pc, commit_valid          next PC, sampled on a commit in EXEC
//   imem_req_valid/ready/addr      fetch request channel
//   imem_rsp_valid/ready/data/err  fetch response channel
//   inst_valid/ready, inst,
//   inst_pc, inst_fault            instruction channel to decode

module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,

  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        commit_valid,

  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,

  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,

  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;
  logic        inst_valid_q, inst_valid_d;
  logic        req_valid_q, req_valid_d;
  logic        rsp_ready_q, rsp_ready_d;

  // Next-state and datapath logic for one fetch-execute round trip.
  //
  // The handshake flags are registered. Their next values are decoded from
  // the next state, so each flag is already correct in the first cycle of
  // its state. A commit in cycle N therefore shows imem_req_valid in N+1.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        // A misaligned pc skips memory entirely and reports a fault.
        if (!pc_is_aligned(pc_q)) begin
          inst_d       = 32'h0;
          inst_pc_d    = pc_q;
          inst_fault_d = 1'b1;
          state_d      = ST_OUT;
        end else if (req_valid_q && imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (rsp_ready_q && imem_rsp_valid) begin
          inst_d       = imem_rsp_data;
          inst_pc_d    = pc_q;
          inst_fault_d = imem_rsp_err;
          state_d      = ST_OUT;
        end
      end

      ST_OUT: begin
        if (inst_valid_q && inst_ready) begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // This is the only place pc changes. Commits seen in any other
        // state are dropped.
        if (commit_valid) begin
          pc_d    = next_pc;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_valid_d  = (state_d == ST_REQ) && pc_is_aligned(pc_d);
    rsp_ready_d  = (state_d == ST_WAIT);
    inst_valid_d = (state_d == ST_OUT);
  end

  // State register. An asynchronous reset drops any outstanding fetch.
  // A late response is then ignored, because rsp_ready stays low until a
  // new request has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_fault_q <= 1'b0;
      inst_valid_q <= 1'b0;
      req_valid_q  <= 1'b0;
      rsp_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
      inst_valid_q <= inst_valid_d;
      req_valid_q  <= req_valid_d;
      rsp_ready_q  <= rsp_ready_d;
    end
  end

  // The request address is the whole pc register, with no masking. It is
  // stable while a request is pending because pc only moves in EXEC.
  assign pc             = pc_q;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = req_valid_q;
  assign imem_rsp_ready = rsp_ready_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = inst_fault_q;

endmodule : ifu

// File: tb/tb_ifu.sv
// tb_ifu - self-checking bench for the instruction fetch unit.
//
// A directed sequence covers reset, latency, back-pressure, misalignment,
// error responses and reset during a fetch. It is followed by a randomized
// series of fetch-execute rounds. Those rounds are checked against a
// transaction-level expectation: the address fetched, the word returned
// and the fault flag that decode should see.

module tb_ifu;
  import npc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        commit_valid;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int checks;
  int failures;

  ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .next_pc        (next_pc),
    .commit_valid   (commit_valid),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle. Outputs are sampled 1 unit after the rising edge,
  // and the inputs for the next edge are driven in the same place.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req_rdy, input logic rsp_vld,
                               input logic [31:0] rsp_dat, input logic rsp_e,
                               input logic ins_rdy, input logic cmt,
                               input logic [31:0] npc);
    imem_req_ready = req_rdy;
    imem_rsp_valid = rsp_vld;
    imem_rsp_data  = rsp_dat;
    imem_rsp_err   = rsp_e;
    inst_ready     = ins_rdy;
    commit_valid   = cmt;
    next_pc        = npc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {31'b0, observed}, {31'b0, expected});
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"}, pc, 32'h8000_0000);
    checkOutput({tag, "_inst"}, inst, 32'h0);
    checkOutput({tag, "_inst_pc"}, inst_pc, 32'h0);
    checkFlag({tag, "_fault"}, inst_fault, 1'b0);
    checkFlag({tag, "_inst_valid"}, inst_valid, 1'b0);
    checkFlag({tag, "_req_valid"}, imem_req_valid, 1'b0);
    checkFlag({tag, "_rsp_ready"}, imem_rsp_ready, 1'b0);
  endtask

  initial begin
    logic [31:0] model_pc;
    logic [31:0] exp_inst;
    logic        exp_fault;
    logic [31:0] new_pc;
    int          stall;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;

    // Memory answers immediately with 0x413; decode not yet ready.
    applyStimulus(1'b1, 1'b1, 32'h0000_0413, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkResetValues("reset");

    // Cycle 0 is IDLE; the request appears in cycle 1 and the instruction
    // in cycle 3.
    rst_n = 1'b1;
    checkFlag("c0_req_valid", imem_req_valid, 1'b0);
    tick();
    checkFlag("c1_req_valid", imem_req_valid, 1'b1);
    checkOutput("c1_req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    checkFlag("c2_rsp_ready", imem_rsp_ready, 1'b1);
    checkFlag("c2_req_valid", imem_req_valid, 1'b0);
    tick();
    checkFlag("c3_inst_valid", inst_valid, 1'b1);
    checkOutput("c3_inst", inst, 32'h0000_0413);
    checkOutput("c3_inst_pc", inst_pc, 32'h8000_0000);
    checkFlag("c3_fault", inst_fault, 1'b0);

    // Decode stalls for 5 cycles while stray commits and responses arrive.
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkFlag("out_hold_valid", inst_valid, 1'b1);
      checkOutput("out_hold_inst", inst, 32'h0000_0413);
      checkOutput("out_hold_inst_pc", inst_pc, 32'h8000_0000);
      checkFlag("out_hold_fault", inst_fault, 1'b0);
      checkOutput("out_hold_pc", pc, 32'h8000_0000);
    end
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkFlag("exec_inst_valid", inst_valid, 1'b0);
    inst_ready = 1'b0;
    tick();
    checkOutput("exec_spurious_inst", inst, 32'h0000_0413);
    checkFlag("exec_spurious_fault", inst_fault, 1'b0);
    checkOutput("exec_pc", pc, 32'h8000_0000);
    checkFlag("exec_rsp_ready", imem_rsp_ready, 1'b0);

    // A misaligned target produces a faulting bubble without a request.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0102);
    tick();
    commit_valid = 1'b0;
    checkOutput("mis_pc", pc, 32'h8000_0102);
    checkFlag("mis_req_valid", imem_req_valid, 1'b0);
    tick();
    checkFlag("mis_req_valid2", imem_req_valid, 1'b0);
    checkFlag("mis_inst_valid", inst_valid, 1'b1);
    checkFlag("mis_fault", inst_fault, 1'b1);
    checkOutput("mis_inst", inst, 32'h0);
    checkOutput("mis_inst_pc", inst_pc, 32'h8000_0102);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // Memory refuses the request for 4 cycles.
    applyStimulus(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 32'h8000_0200);
    tick();
    commit_valid = 1'b0;
    checkFlag("bp_req_valid", imem_req_valid, 1'b1);
    checkOutput("bp_req_addr", imem_req_addr, 32'h8000_0200);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkFlag("bp_hold_valid", imem_req_valid, 1'b1);
      checkOutput("bp_hold_addr", imem_req_addr, 32'h8000_0200);
      checkFlag("bp_hold_rsp_ready", imem_rsp_ready, 1'b0);
    end
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    checkFlag("bp_wait_rsp_ready", imem_rsp_ready, 1'b1);
    checkFlag("bp_wait_req_valid", imem_req_valid, 1'b0);

    // An error response still delivers its data, with the fault flag set.
    applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    checkFlag("err_inst_valid", inst_valid, 1'b1);
    checkFlag("err_fault", inst_fault, 1'b1);
    checkOutput("err_inst", inst, 32'hCAFE_F00D);
    checkOutput("err_inst_pc", inst_pc, 32'h8000_0200);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // Reset arrives while a fetch is outstanding.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0300);
    tick();
    commit_valid = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    checkFlag("rw_rsp_ready", imem_rsp_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    checkResetValues("rw_reset");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    tick();
    rst_n = 1'b1;
    tick();
    checkFlag("rw_restart_valid", imem_req_valid, 1'b1);
    checkOutput("rw_restart_addr", imem_req_addr, 32'h8000_0000);
    checkFlag("rw_restart_rsp_ready", imem_rsp_ready, 1'b0);
    checkFlag("rw_restart_inst_valid", inst_valid, 1'b0);
    tick();
    checkFlag("rw_late_rsp_inst_valid", inst_valid, 1'b0);
    checkOutput("rw_late_rsp_inst", inst, 32'h0);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    checkOutput("rw_inst", inst, 32'h0000_0013);
    checkOutput("rw_inst_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // Randomized rounds. Each round starts in EXEC with a commit and ends
    // back in EXEC.
    model_pc = 32'h8000_0000;
    for (int it = 0; it < 40; it++) begin
      new_pc = $urandom;
      if ($urandom_range(0, 3) != 0) new_pc[1:0] = 2'b00;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, new_pc);
      tick();
      commit_valid = 1'b0;
      model_pc = new_pc;
      checkOutput("rnd_pc", pc, model_pc);

      if (model_pc[1:0] == 2'b00) begin
        checkFlag("rnd_req_valid", imem_req_valid, 1'b1);
        checkOutput("rnd_req_addr", imem_req_addr, model_pc);
        stall = $urandom_range(0, 3);
        for (int k = 0; k < stall; k++) begin
          imem_rsp_valid = 1'($urandom_range(0, 1));
          imem_rsp_data  = $urandom;
          tick();
          checkFlag("rnd_req_hold", imem_req_valid, 1'b1);
          checkOutput("rnd_addr_hold", imem_req_addr, model_pc);
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        checkFlag("rnd_rsp_ready", imem_rsp_ready, 1'b1);
        stall = $urandom_range(0, 3);
        for (int k = 0; k < stall; k++) tick();
        exp_inst  = $urandom;
        exp_fault = 1'($urandom_range(0, 1));
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = exp_inst;
        imem_rsp_err   = exp_fault;
        tick();
        imem_rsp_valid = 1'b0;
      end else begin
        checkFlag("rnd_no_req", imem_req_valid, 1'b0);
        exp_inst  = 32'h0;
        exp_fault = 1'b1;
        tick();
      end

      checkFlag("rnd_inst_valid", inst_valid, 1'b1);
      checkOutput("rnd_inst", inst, exp_inst);
      checkOutput("rnd_inst_pc", inst_pc, model_pc);
      checkFlag("rnd_fault", inst_fault, exp_fault);

      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        commit_valid = 1'($urandom_range(0, 1));
        next_pc      = $urandom;
        tick();
        checkOutput("rnd_out_inst", inst, exp_inst);
        checkOutput("rnd_out_pc", pc, model_pc);
      end
      commit_valid = 1'b0;
      inst_ready   = 1'b1;
      tick();
      inst_ready   = 1'b0;
      checkFlag("rnd_exec_valid", inst_valid, 1'b0);

      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rsp_data  = $urandom;
        tick();
        checkOutput("rnd_exec_inst", inst, exp_inst);
        checkOutput("rnd_exec_pc", pc, model_pc);
      end
      imem_rsp_valid = 1'b0;
    end

    $display("[TB] directed and randomized sequences complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ifu
